video_stream_packer: RTL and testbench

Parametrised successor to the fractal pixel streamer. It accepts one pixel per handshake from the fractal compute core, packs several pixels into each AXI4-Stream beat, and tracks raster position. It generates `tuser` at start of frame and `tlast` at end of line or end of frame, and honours downstream back-pressure with no data loss. It sits between the compute core and the VDMA/video output stream.

---
 rtl/video_stream_pkg.sv | 25 ++
 rtl/raster_counter.sv | 48 ++++
 rtl/video_stream_packer.sv | 152 +++++++++++++++
 tb/tb_video_stream_packer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_stream_pkg.sv
// video_stream_pkg
// Shared definitions for the video stream packer:
//   - LAST_LINE / LAST_FRAME : encodings of the LAST_MODE parameter
//   - state_t                : packer control state (IDLE, RUN)
//   - clog2()                : counter width helper, never returns less than 1
package video_stream_pkg;

  localparam int LAST_LINE  = 0;  // tlast on the last beat of every line
  localparam int LAST_FRAME = 1;  // tlast on the last beat of the frame only

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width needed to hold 0..value-1. The minimum is 1 so that a degenerate
  // size such as one pixel per beat still yields a legal vector.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter
// Tracks the raster position of the current beat. x is measured in pixels
// and advances by STEP on every step pulse; it wraps at X_SIZE and then
// bumps y, which wraps at Y_SIZE.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   step       : advance the position by one beat
//   x, y       : pixel column of the beat's first pixel, line number
//   eol        : current position is the last beat of its line
//   eof        : current position is the last beat of the frame
module raster_counter
  import video_stream_pkg::*;
#(
  parameter  int X_SIZE = 640,
  parameter  int Y_SIZE = 480,
  parameter  int STEP   = 4,
  localparam int X_W    = clog2(X_SIZE),
  localparam int Y_W    = clog2(Y_SIZE)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           step,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           eol,
  output logic           eof
);

  assign eol = (x == X_W'(X_SIZE - STEP));
  assign eof = eol && (y == Y_W'(Y_SIZE - 1));

  // NOTE: clocked state is assigned with <= so every register samples the
  // pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (step) begin
      if (eol) begin
        x <= '0;
        y <= eof ? '0 : y + 1'b1;
      end else begin
        x <= x + X_W'(STEP);
      end
    end
  end

endmodule

// File: rtl/video_stream_packer.sv
// video_stream_packer
// Packs PPB = DATA_W/PIX_W pixels (little-endian, lane 0 in the low bits)
// into each AXI4-Stream beat, marks start of frame with tuser and end of
// line/frame with tlast, and stalls the pixel source only when a completed
// beat cannot be handed downstream.
// Ports:
//   out_stream_aclk, axi_resetn : clock, asynchronous active-low reset
//   enable                      : permit a new frame to start
//   pix_tdata/tvalid/tready     : pixel input handshake
//   out_stream_tdata/tkeep/tuser/tlast/tvalid/tready : packed output stream
//   busy                        : a frame is in progress
//   frame_done                  : pulse after the final beat of a frame leaves
module video_stream_packer
  import video_stream_pkg::*;
#(
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480,
  parameter int PIX_W     = 8,
  parameter int DATA_W    = 32,
  parameter int LAST_MODE = LAST_LINE
) (
  input  logic                out_stream_aclk,
  input  logic                axi_resetn,
  input  logic                enable,
  input  logic [PIX_W-1:0]    pix_tdata,
  input  logic                pix_tvalid,
  output logic                pix_tready,
  output logic [DATA_W-1:0]   out_stream_tdata,
  output logic [DATA_W/8-1:0] out_stream_tkeep,
  output logic                out_stream_tuser,
  output logic                out_stream_tlast,
  output logic                out_stream_tvalid,
  input  logic                out_stream_tready,
  output logic                busy,
  output logic                frame_done
);

  localparam int PPB    = DATA_W / PIX_W;
  localparam int LANE_W = clog2(PPB);
  localparam int X_W    = clog2(X_SIZE);
  localparam int Y_W    = clog2(Y_SIZE);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PPB - 1);

  if (DATA_W % PIX_W != 0) begin : g_chk_pix_w
    $error("PIX_W must divide DATA_W");
  end
  if (X_SIZE % PPB != 0) begin : g_chk_x_size
    $error("X_SIZE must be a multiple of the pixels per beat");
  end
  if (DATA_W % 8 != 0) begin : g_chk_data_w
    $error("DATA_W must be a multiple of 8");
  end

  state_t            state, state_nxt;
  logic [LANE_W-1:0] lane;
  logic [DATA_W-1:0] staging;
  logic [DATA_W-1:0] beat_data;
  logic              accept;
  logic              beat_load;
  logic              out_hs;
  logic              out_eof;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic              eol;
  logic              eof;

  assign out_stream_tkeep = '1;
  assign busy             = (state == RUN);

  // Only the pixel that completes a beat needs the output register to be
  // free; the other lanes just fill the staging register.
  assign pix_tready = busy && ((lane != LAST_LANE) || !out_stream_tvalid || out_stream_tready);
  assign accept     = pix_tvalid && pix_tready;
  assign beat_load  = accept && (lane == LAST_LANE);
  assign out_hs     = out_stream_tvalid && out_stream_tready;

  raster_counter #(
    .X_SIZE (X_SIZE),
    .Y_SIZE (Y_SIZE),
    .STEP   (PPB)
  ) u_raster (
    .clk   (out_stream_aclk),
    .rst_n (axi_resetn),
    .step  (beat_load),
    .x     (x),
    .y     (y),
    .eol   (eol),
    .eof   (eof)
  );

  // The incoming pixel is the top lane of the beat, so it bypasses staging.
  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    beat_data                           = staging;
    beat_data[DATA_W-PIX_W +: PIX_W]    = pix_tdata;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (beat_load && eof && !enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state <= IDLE;
      lane  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) lane <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
    end
  end

  // NOTE: staging is a plain register rather than a RAM, so it takes the
  // async reset like everything else; a discarded partial frame leaves no
  // stale lanes behind.
  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      staging <= '0;
    end else if (accept && !beat_load) begin
      staging[lane*PIX_W +: PIX_W] <= pix_tdata;
    end
  end

  // A load in the same cycle as a handshake keeps tvalid high with new data.
  always_ff @(posedge out_stream_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      out_stream_tdata  <= '0;
      out_stream_tuser  <= 1'b0;
      out_stream_tlast  <= 1'b0;
      out_stream_tvalid <= 1'b0;
      out_eof           <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      frame_done <= out_hs && out_eof;
      if (beat_load) begin
        out_stream_tdata  <= beat_data;
        out_stream_tuser  <= (x == '0) && (y == '0);
        out_stream_tlast  <= (LAST_MODE == LAST_LINE) ? eol : eof;
        out_stream_tvalid <= 1'b1;
        out_eof           <= eof;
      end else if (out_hs) begin
        out_stream_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_stream_packer.sv
// tb_video_stream_packer
// Drives two packers (LAST_MODE 0 and 1) from the same stimulus with an
// 8-pixel x 2-line frame of 8-bit pixels packed four per 32-bit beat.
// Expected beats are queued as stimulus is issued; a monitor pops and
// compares them on every output handshake.
module tb_video_stream_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  pix_tdata = '0;
  logic        pix_tvalid = 1'b0;
  logic        out_tready = 1'b1;

  logic        pix_tready0, pix_tready1;
  logic [31:0] tdata0, tdata1;
  logic [3:0]  tkeep0, tkeep1;
  logic        tuser0, tuser1, tlast0, tlast1, tvalid0, tvalid1;
  logic        busy0, busy1, fdone0, fdone1;

  always #5 clk = ~clk;

  video_stream_packer #(
    .X_SIZE(8), .Y_SIZE(2), .PIX_W(8), .DATA_W(32), .LAST_MODE(0)
  ) dut0 (
    .out_stream_aclk   (clk),
    .axi_resetn        (rst_n),
    .enable            (enable),
    .pix_tdata         (pix_tdata),
    .pix_tvalid        (pix_tvalid),
    .pix_tready        (pix_tready0),
    .out_stream_tdata  (tdata0),
    .out_stream_tkeep  (tkeep0),
    .out_stream_tuser  (tuser0),
    .out_stream_tlast  (tlast0),
    .out_stream_tvalid (tvalid0),
    .out_stream_tready (out_tready),
    .busy              (busy0),
    .frame_done        (fdone0)
  );

  video_stream_packer #(
    .X_SIZE(8), .Y_SIZE(2), .PIX_W(8), .DATA_W(32), .LAST_MODE(1)
  ) dut1 (
    .out_stream_aclk   (clk),
    .axi_resetn        (rst_n),
    .enable            (enable),
    .pix_tdata         (pix_tdata),
    .pix_tvalid        (pix_tvalid),
    .pix_tready        (pix_tready1),
    .out_stream_tdata  (tdata1),
    .out_stream_tkeep  (tkeep1),
    .out_stream_tuser  (tuser1),
    .out_stream_tlast  (tlast1),
    .out_stream_tvalid (tvalid1),
    .out_stream_tready (out_tready),
    .busy              (busy1),
    .frame_done        (fdone1)
  );

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last0;
    logic        last1;
    logic        eof;
  } beat_t;

  // Hand-computed beats of one frame of pixels 0x00..0x0F.
  localparam logic [31:0] BEAT_DATA [4] = '{32'h03020100, 32'h07060504,
                                            32'h0B0A0908, 32'h0F0E0D0C};
  localparam logic        BEAT_USER [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic        BEAT_LAST0[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic        BEAT_LAST1[4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  beat_t sb[$];
  int    vectors = 0;
  int    errors  = 0;
  int    fd_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beats(input int count);
    beat_t b;
    for (int i = 0; i < count; i++) begin
      b.data  = BEAT_DATA[i];
      b.user  = BEAT_USER[i];
      b.last0 = BEAT_LAST0[i];
      b.last1 = BEAT_LAST1[i];
      b.eof   = (i == 3);
      sb.push_back(b);
    end
  endtask

  // Entered at a falling edge; returns at the falling edge after the pixel
  // has been accepted, leaving pix_tvalid high.
  task automatic send_pix(input logic [7:0] p);
    bit acc;
    acc = 1'b0;
    pix_tdata  = p;
    pix_tvalid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      #1 acc = pix_tready0;
      @(negedge clk);
    end
    if (!acc) begin
      vectors++;
      errors++;
      $display("FAIL pix_accept_timeout: pixel 0x%0h never accepted, expected acceptance", p);
    end
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) send_pix(8'(i));
  endtask

  // Monitor: samples late in the low phase, after all drivers have settled.
  initial begin
    beat_t       e;
    logic        fd_exp    = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] held      = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        fd_exp     = 1'b0;
        stall_prev = 1'b0;
      end else begin
        check("frame_done0", fdone0, fd_exp);
        check("frame_done1", fdone1, fd_exp);
        if (fdone0) fd_count++;
        if (stall_prev) begin
          check("held_tvalid", tvalid0, 1'b1);
          check("held_tdata", tdata0, held);
        end
        check("tvalid_match", tvalid1, tvalid0);
        fd_exp = 1'b0;
        if (tvalid0 && out_tready) begin
          if (sb.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", tdata0);
          end else begin
            e = sb.pop_front();
            check("tdata0", tdata0, e.data);
            check("tuser0", tuser0, e.user);
            check("tlast0", tlast0, e.last0);
            check("tkeep0", tkeep0, 4'hF);
            check("tdata1", tdata1, e.data);
            check("tuser1", tuser1, e.user);
            check("tlast1", tlast1, e.last1);
            fd_exp = e.eof;
          end
        end
        stall_prev = tvalid0 && !out_tready;
        held       = tdata0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Scenario 1: reset state.
    repeat (3) begin
      @(negedge clk);
      check("rst_tvalid", tvalid0, 1'b0);
      check("rst_pix_tready", pix_tready0, 1'b0);
      check("rst_busy", busy0, 1'b0);
      check("rst_tkeep", tkeep0, 4'hF);
      check("rst_frame_done", fdone0, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("idle_pix_tready", pix_tready0, 1'b0);

    // Scenarios 2 and 4: continuous stream, both tlast modes compared.
    enable = 1'b1;
    push_beats(4);
    send_range(0, 15);

    // Scenario 3: back-to-back frame with a 5-cycle stall after the first beat.
    push_beats(4);
    fork
      send_range(0, 15);
      begin
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          seen = tvalid0 && tuser0;
        end
        if (!seen) begin
          vectors++;
          errors++;
          $display("FAIL first_beat_timeout: tuser beat not seen, expected within 50 cycles");
        end
        @(negedge clk);
        out_tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          #1 check("stall_pix_tready", pix_tready0 && tvalid0 ? 1'b1 : pix_tready0, pix_tready0);
        end
        out_tready = 1'b1;
      end
    join

    // Scenario 5: enable dropped after pixel 5; frame still completes.
    push_beats(4);
    send_range(0, 5);
    enable = 1'b0;
    send_range(6, 15);
    check("busy_after_last", busy0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      #1 check("idle_no_ready", pix_tready0, 1'b0);
    end
    pix_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_idle", busy0, 1'b0);

    // Scenario 6: reset mid-frame after pixel 6, then a full fresh frame.
    enable = 1'b1;
    push_beats(1);
    send_range(0, 6);
    rst_n      = 1'b0;
    pix_tvalid = 1'b0;
    #1;
    check("midrst_tvalid", tvalid0, 1'b0);
    check("midrst_busy", busy0, 1'b0);
    check("midrst_pix_tready", pix_tready0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_beats(4);
    send_range(0, 15);
    pix_tvalid = 1'b0;
    enable     = 1'b0;

    for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("frame_done_count", fd_count, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
